mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width in bits (WIDTH >= 4).
REQ-002 One clock; reset is synchronous and active-high: clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 mdOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
REQ-006 din1  input  WIDTH  multiplicand / dividend / mthi-mtlo source.
REQ-007 din2  input  WIDTH  multiplier / divisor.
REQ-008 cancel  input  1  abort the in-flight operation (pipeline flush).
REQ-009 busy  output  1  high while an operation is in flight (state != IDLE).
REQ-010 done  output  1  one-cycle pulse when HI/LO are written by mult/multu/div/divu.
REQ-011 hi  output  WIDTH  HI register contents.
REQ-012 lo  output  WIDTH  LO register contents.
REQ-013 divZero  output  1  high with done when the completed div/divu had din2 == 0; low otherwise.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and FIX; busy SHALL equal (state != IDLE), decoded from registered state.
REQ-015 In IDLE with start=1, cancel=0 and mdOp in {000..011}, the edge SHALL latch din1, din2 and mdOp, clear the bit counter, and enter RUN.
REQ-016 In IDLE with start=1, cancel=0 and mdOp=100 (101), the edge SHALL write din1 to hi (lo), stay in IDLE, and leave done low.
REQ-017 start with mdOp 110/111, start outside IDLE, and start while cancel=1 SHALL all be ignored.
REQ-018 Signed ops SHALL convert operands to magnitudes at latch time; unsigned ops SHALL use operands unchanged.
REQ-019 RUN SHALL process exactly one bit per edge (shift-add multiply, restoring divide) for WIDTH edges, then enter FIX.
REQ-020 FIX SHALL apply sign correction; the FIX->IDLE edge SHALL write hi/lo, set done=1 for exactly one cycle, and set divZero.
REQ-021 Latency: start sampled at edge E0; busy high from E0 to E(WIDTH+1) (WIDTH+1 cycles); hi/lo valid and done high after E(WIDTH+1).
REQ-022 A new start SHALL be accepted in the done cycle, i.e. at E(WIDTH+2).
REQ-023 mult/multu: {hi,lo} SHALL hold the full 2*WIDTH-bit product.
REQ-024 mult: product SHALL be negated when the operand signs differ.
REQ-025 div/divu: lo = quotient, hi = remainder; quotient truncates toward zero.
REQ-026 Signed division: quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-027 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0, divZero = 0, no exception.
REQ-028 Divide by zero (div or divu): latency unchanged; hi = latched din1, lo = all ones, divZero = 1.
REQ-029 cancel=1 in RUN or FIX: next edge SHALL return to IDLE with no hi/lo write and no done pulse.
REQ-030 cancel in IDLE SHALL have no effect other than blocking a simultaneous start.
REQ-031 divZero SHALL hold until the next done pulse or reset.
REQ-032 hi/lo SHALL change only on mthi/mtlo, on completion, or on reset; they SHALL never change mid-operation.

Reset
REQ-033 rst=1 SHALL force state IDLE, busy=0, done=0, divZero=0, hi=0, lo=0 and counter=0 at the next edge, overriding all other inputs.
REQ-034 rst during RUN/FIX SHALL abort the operation with no done pulse; start is accepted normally on the first edge after rst deasserts.

Verification (WIDTH=32)
REQ-035 multu din1=FFFFFFFF, din2=FFFFFFFF -> after E33 hi=FFFFFFFE, lo=00000001, done=1 for one cycle, busy was high for 33 cycles.
REQ-036 mult din1=FFFFFFFD (-3), din2=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; then div din1=FFFFFFF9 (-7), din2=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 div din1=80000000, din2=FFFFFFFF -> lo=80000000, hi=00000000, divZero=0.
REQ-038 divu din1=00000005, din2=00000000 -> hi=00000005, lo=FFFFFFFF, divZero=1, done after E33.
REQ-039 mtlo din1=12345678, then multu started and cancel asserted at E10 -> busy low after E11, no done, lo stays 12345678; a start issued during busy is ignored.
REQ-040 rst asserted at E5 of a div -> hi=lo=0, busy=0, no done; a multu 2x3 issued next completes with lo=00000006 after 33 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative multiply/divide unit with HI/LO result registers.
//               Produces one result bit per clock in RUN. The FIX cycle
//               applies sign correction and then writes HI/LO.
//               mthi/mtlo write HI/LO directly from IDLE.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, mdOp         - operation request and opcode
//                                     (000 mult, 001 multu, 010 div,
//                                      011 divu, 100 mthi, 101 mtlo)
//               din1, din2          - operands
//               cancel              - flush the in-flight operation
//               busy, done          - in-flight flag, completion pulse
//               hi, lo              - result registers
//               divZero             - last completed divide had din2 == 0
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divZero
);

    localparam int                c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_is_mul;   // 1: multiply, 0: divide
    logic                 r_neg_q;    // negate product / quotient in FIX
    logic                 r_neg_r;    // negate remainder in FIX
    logic [WIDTH-1:0]     r_a;        // product high half / partial remainder
    logic [WIDTH-1:0]     r_q;        // multiplier/product low half or dividend/quotient
    logic [WIDTH-1:0]     r_b;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_orig1;    // unmodified din1, reported as HI on divide by zero
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_divzero;

    logic                 w_accept;
    logic                 w_mthi;
    logic                 w_mtlo;
    logic                 w_commit;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !cancel) begin
                    case (mdOp)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            w_accept = 1'b1;
                            w_next   = RUN;
                        end
                        3'b100:  w_mthi = 1'b1;
                        3'b101:  w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    w_next = IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_next   = IDLE;
                w_commit = !cancel;
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning at latch time
    // ------------------------------------------------------------------
    logic             w_signed;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    always_comb begin
        w_signed = ~mdOp[0];
        w_s1     = w_signed & din1[WIDTH-1];
        w_s2     = w_signed & din2[WIDTH-1];
        w_mag1   = w_s1 ? -din1 : din1;
        w_mag2   = w_s2 ? -din2 : din2;
    end

    // ------------------------------------------------------------------
    // One iteration step: shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_a_step;
    logic [WIDTH-1:0] w_q_step;

    always_comb begin
        w_sum   = {1'b0, r_a} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shift = {r_a, r_q[WIDTH-1]};
        w_sub   = w_shift - {1'b0, r_b};
        w_ge    = (w_shift >= {1'b0, r_b});
        if (r_is_mul) begin
            // Product accumulates in r_a while the multiplier drains out of r_q.
            w_a_step = w_sum[WIDTH:1];
            w_q_step = {w_sum[0], r_q[WIDTH-1:1]};
        end else begin
            w_a_step = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_q_step = {r_q[WIDTH-2:0], w_ge};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_dz;

    always_comb begin
        w_prod = r_neg_q ? -{r_a, r_q} : {r_a, r_q};
        // most-negative / -1 needs no special case: the unsigned quotient
        // magnitude already equals the most-negative bit pattern.
        w_quo  = r_neg_q ? -r_q : r_q;
        w_rem  = r_neg_r ? -r_a : r_a;
        w_dz   = ~r_is_mul && (r_b == '0);
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_a       <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_orig1   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt    <= '0;
                r_is_mul <= ~mdOp[1];
                r_neg_q  <= w_s1 ^ w_s2;
                r_neg_r  <= w_s1;
                r_a      <= '0;
                r_q      <= w_mag1;
                r_b      <= w_mag2;
                r_orig1  <= din1;
            end
            if (w_mthi) begin
                r_hi <= din1;
            end
            if (w_mtlo) begin
                r_lo <= din1;
            end
            if (r_state == RUN && !cancel) begin
                r_cnt <= r_cnt + 1'b1;
                r_a   <= w_a_step;
                r_q   <= w_q_step;
            end
            if (w_commit) begin
                r_done    <= 1'b1;
                r_divzero <= w_dz;
                if (r_is_mul) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (w_dz) begin
                    r_hi <= r_orig1;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign divZero = r_divzero;

endmodule
`default_nettype wire
